gemm_insn_encoder: RTL and testbench
====================================

Name: gemm_insn_encoder

Overview:
- Issue-side counterpart of the GEMM core's instruction input.
- Accepts GEMM commands as discrete fields, validates them and packs each into the 128-bit VTA GEMM instruction word.
- Buffers packed words in a small FIFO and presents them to the gemm core over a valid/ready handshake.
- Sits between the host/command sequencer and the gemm core's insn port.

Parameters:
- INS_WIDTH, 128, packed instruction width (fixed layout; other values unsupported)
- DEPTH, 4, FIFO entries (power of two, >=2)
- CNT_WIDTH, 16, width of issued-instruction counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  encoder can accept command
- cmd_dep  in  4  {push_next,push_prev,pop_next,pop_prev} dependency flags
- cmd_reset_reg  in  1  reset_reg flag
- cmd_uop_bgn  in  13  micro-op begin index
- cmd_uop_end  in  14  micro-op end index (exclusive)
- cmd_iter_out  in  14  outer loop count
- cmd_iter_in  in  14  inner loop count
- cmd_dst_out, cmd_dst_in  in  11 each  accumulator factors
- cmd_src_out, cmd_src_in  in  11 each  input factors
- cmd_wgt_out, cmd_wgt_in  in  10 each  weight factors
- insn  out  INS_WIDTH  packed instruction at FIFO head
- insn_valid  out  1  insn holds a valid instruction
- insn_ready  in  1  core consumes insn
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- err  out  1  one-cycle pulse: command rejected
- issue_cnt  out  CNT_WIDTH  instructions handed to core, wraps

Behaviour:
- Packing:
  - [2:0] = 3'd2 (GEMM opcode, constant).
  - [6:3] = cmd_dep.
  - [7] = reset_reg.
  - [20:8] uop_bgn, [34:21] uop_end, [48:35] iter_out, [62:49] iter_in.
  - [73:63] dst_out, [84:74] dst_in, [95:85] src_out, [106:96] src_in.
  - [116:107] wgt_out, [126:117] wgt_in.
  - [127] = 0.
  - Fields are zero-extended only, never truncated.
- cmd_ready = (level < DEPTH); it depends only on registered state, never combinationally on cmd_valid or insn_ready.
- Accept: cmd_valid && cmd_ready.
  - Valid command: written at the write pointer; level increments next edge.
  - Invalid command (see Optional Feature): consumed but not written; err = 1 for exactly the next cycle.
- Output:
  - insn_valid = (level != 0); insn = the head entry, driven from registered storage.
  - While insn_valid && !insn_ready, insn and insn_valid are held stable.
  - Pop on insn_valid && insn_ready: read pointer advances, issue_cnt += 1 (wraps at 2^CNT_WIDTH).
- Latency: a command accepted into an empty FIFO appears on insn/insn_valid the following cycle; there is no bypass.
- Simultaneous push and pop: level is unchanged and both pointers advance.
  - Full with a pop in the same cycle: cmd_ready is still 0 that cycle; the push is taken next cycle.
  - Empty with a push: no pop is possible that cycle.
- Pointers are log2(DEPTH) bits and wrap naturally; full/empty are determined from level.
- Reset (any time, including mid-transfer): level = 0, pointers = 0, insn = 0, insn_valid = 0, cmd_ready = 1 after release, err = 0, issue_cnt = 0. Stored entries are discarded.
- Outputs are registered or derived from registered state only.

Optional Feature:
- Macro GEMM_ENC_CHECK_EN.
- Defined: a command is invalid if uop_end <= uop_bgn (13-bit uop_bgn compared zero-extended), iter_out == 0, or iter_in == 0. An invalid command is dropped and err pulses.
- Undefined: every accepted command is packed and queued unchanged; err is tied to 0.

Test Plan:
- Single command, all fields 1, uop_bgn=1, uop_end=16, insn_ready=1 -> one cycle after accept:
  - insn_valid=1, insn[2:0]=2, insn[20:8]=1, insn[34:21]=16, all other factor and iter fields =1, insn[127]=0.
  - Pop that cycle; issue_cnt=1; level returns to 0.
- insn_ready=0, push 5 distinct commands (DEPTH=4) -> cmd_ready drops after the 4th; level=4; 5th held off; insn stays equal to the 1st command.
- From full, raise insn_ready with cmd_valid held -> 5th command accepted the cycle after the first pop; outputs appear in FIFO order 1..5; issue_cnt=5.
- With GEMM_ENC_CHECK_EN: uop_bgn=16, uop_end=16 -> err=1 for one cycle, level unchanged. iter_in=0 -> err again. Without the macro: both commands queue, err stays 0.
- Continuous push and pop every cycle with insn_ready=1 over 20 commands -> level stays at 1, no bubbles after the first, issue_cnt=20.
- Assert rst low with level=3 and insn_valid=1 mid-stall -> immediately insn_valid=0, insn=0, level=0, issue_cnt=0; after release cmd_ready=1 and the next command issues correctly.

Source files
------------

// File: rtl/gemm_insn_encoder_if.sv
// Command and instruction handshake bundle for gemm_insn_encoder.
// The master side drives commands and consumes instructions.
// The slave side is the encoder itself.
interface gemm_insn_encoder_if #(
  parameter int INS_WIDTH = 128
);

  // command side
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_dep;
  logic                 cmd_reset_reg;
  logic [12:0]          cmd_uop_bgn;
  logic [13:0]          cmd_uop_end;
  logic [13:0]          cmd_iter_out;
  logic [13:0]          cmd_iter_in;
  logic [10:0]          cmd_dst_out;
  logic [10:0]          cmd_dst_in;
  logic [10:0]          cmd_src_out;
  logic [10:0]          cmd_src_in;
  logic [9:0]           cmd_wgt_out;
  logic [9:0]           cmd_wgt_in;

  // instruction side
  logic [INS_WIDTH-1:0] insn;
  logic                 insn_valid;
  logic                 insn_ready;

  modport master (
    output cmd_valid, cmd_dep, cmd_reset_reg, cmd_uop_bgn, cmd_uop_end,
    output cmd_iter_out, cmd_iter_in, cmd_dst_out, cmd_dst_in,
    output cmd_src_out, cmd_src_in, cmd_wgt_out, cmd_wgt_in,
    input  cmd_ready,
    input  insn, insn_valid,
    output insn_ready
  );

  modport slave (
    input  cmd_valid, cmd_dep, cmd_reset_reg, cmd_uop_bgn, cmd_uop_end,
    input  cmd_iter_out, cmd_iter_in, cmd_dst_out, cmd_dst_in,
    input  cmd_src_out, cmd_src_in, cmd_wgt_out, cmd_wgt_in,
    output cmd_ready,
    output insn, insn_valid,
    input  insn_ready
  );

endinterface

// File: rtl/gemm_insn_encoder.sv
// GEMM instruction encoder: packs discrete command fields into the 128-bit
// VTA GEMM instruction word and queues them in a small FIFO ahead of the
// gemm core's instruction port.
// Optional command validation is enabled by defining GEMM_ENC_CHECK_EN;
// invalid commands are then dropped and flagged by a one-cycle err pulse.
module gemm_insn_encoder #(
  parameter int INS_WIDTH = 128,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  gemm_insn_encoder_if.slave     bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err,
  output logic [CNT_WIDTH-1:0]   issue_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [INS_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [INS_WIDTH-1:0] packed_cmd;
  logic                 cmd_ok;
  logic                 accept;
  logic                 push;
  logic                 pop;

  // Handshake outputs depend only on registered occupancy and storage.
  assign bus.cmd_ready  = (level < LW'(DEPTH));
  assign bus.insn_valid = (level != '0);
  assign bus.insn       = mem[rd_ptr];

  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign push   = accept && cmd_ok;
  assign pop    = bus.insn_valid && bus.insn_ready;

  // Pack command fields into the instruction word; unused bit 127 stays 0.
  always_comb begin
    packed_cmd          = '0;
    packed_cmd[2:0]     = 3'd2;
    packed_cmd[6:3]     = bus.cmd_dep;
    packed_cmd[7]       = bus.cmd_reset_reg;
    packed_cmd[20:8]    = bus.cmd_uop_bgn;
    packed_cmd[34:21]   = bus.cmd_uop_end;
    packed_cmd[48:35]   = bus.cmd_iter_out;
    packed_cmd[62:49]   = bus.cmd_iter_in;
    packed_cmd[73:63]   = bus.cmd_dst_out;
    packed_cmd[84:74]   = bus.cmd_dst_in;
    packed_cmd[95:85]   = bus.cmd_src_out;
    packed_cmd[106:96]  = bus.cmd_src_in;
    packed_cmd[116:107] = bus.cmd_wgt_out;
    packed_cmd[126:117] = bus.cmd_wgt_in;
  end

`ifdef GEMM_ENC_CHECK_EN
  // Reject empty uop ranges and zero loop counts.
  always_comb begin
    cmd_ok = (bus.cmd_uop_end > {1'b0, bus.cmd_uop_bgn}) &&
             (bus.cmd_iter_out != '0) &&
             (bus.cmd_iter_in  != '0);
  end

  // Pulse err the cycle after a rejected command is consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= accept && !cmd_ok;
    end
  end
`else
  assign cmd_ok = 1'b1;
  assign err    = 1'b0;
`endif

  // FIFO storage, pointers, occupancy and issued-instruction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      issue_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= packed_cmd;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        issue_cnt <= issue_cnt + CNT_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_insn_encoder.sv
// Directed testbench for gemm_insn_encoder with hand-computed expectations.
// Honours GEMM_ENC_CHECK_EN when the design is built with it.
module tb_gemm_insn_encoder;

  typedef struct packed {
    logic [3:0]  dep;
    logic        reset_reg;
    logic [12:0] uop_bgn;
    logic [13:0] uop_end;
    logic [13:0] iter_out;
    logic [13:0] iter_in;
    logic [10:0] dst_out;
    logic [10:0] dst_in;
    logic [10:0] src_out;
    logic [10:0] src_in;
    logic [9:0]  wgt_out;
    logic [9:0]  wgt_in;
  } cmd_t;

  logic         clk;
  logic         rst;
  logic [2:0]   level;
  logic         err;
  logic [15:0]  issue_cnt;
  int           n_tests;
  int           n_fail;
  cmd_t         cmds [5];
  cmd_t         c;
  int           lv [5];
  int           base_cnt;

  gemm_insn_encoder_if #(.INS_WIDTH(128)) bus ();

  gemm_insn_encoder #(
    .INS_WIDTH (128),
    .DEPTH     (4),
    .CNT_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .level     (level),
    .err       (err),
    .issue_cnt (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic cmd_t make_cmd(input int k);
    cmd_t r;
    r.dep       = 4'(k);
    r.reset_reg = 1'(k);
    r.uop_bgn   = 13'(k);
    r.uop_end   = 14'(k + 100);
    r.iter_out  = 14'(k + 1);
    r.iter_in   = 14'(2 * k + 1);
    r.dst_out   = 11'(k * 3);
    r.dst_in    = 11'(k * 5);
    r.src_out   = 11'(k * 7);
    r.src_in    = 11'(2047 - k);
    r.wgt_out   = 10'(1023 - k);
    r.wgt_in    = 10'(k * 9);
    return r;
  endfunction

  // Reference layout built from shifted fields at their documented offsets.
  function automatic logic [127:0] pack_ref(input cmd_t x);
    logic [127:0] r;
    r = 128'd2;
    r = r | (128'(x.dep)       << 3);
    r = r | (128'(x.reset_reg) << 7);
    r = r | (128'(x.uop_bgn)   << 8);
    r = r | (128'(x.uop_end)   << 21);
    r = r | (128'(x.iter_out)  << 35);
    r = r | (128'(x.iter_in)   << 49);
    r = r | (128'(x.dst_out)   << 63);
    r = r | (128'(x.dst_in)    << 74);
    r = r | (128'(x.src_out)   << 85);
    r = r | (128'(x.src_in)    << 96);
    r = r | (128'(x.wgt_out)   << 107);
    r = r | (128'(x.wgt_in)    << 117);
    return r;
  endfunction

  task automatic drive(input cmd_t x);
    bus.cmd_dep       = x.dep;
    bus.cmd_reset_reg = x.reset_reg;
    bus.cmd_uop_bgn   = x.uop_bgn;
    bus.cmd_uop_end   = x.uop_end;
    bus.cmd_iter_out  = x.iter_out;
    bus.cmd_iter_in   = x.iter_in;
    bus.cmd_dst_out   = x.dst_out;
    bus.cmd_dst_in    = x.dst_in;
    bus.cmd_src_out   = x.src_out;
    bus.cmd_src_in    = x.src_in;
    bus.cmd_wgt_out   = x.wgt_out;
    bus.cmd_wgt_in    = x.wgt_in;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.insn_ready = 1'b0;
    drive('0);

    // Reset state
    tick();
    tick();
    check("rst_level", 128'(level), 128'd0);
    check("rst_valid", 128'(bus.insn_valid), 128'd0);
    check("rst_insn", bus.insn, 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_cnt", 128'(issue_cnt), 128'd0);
    rst = 1'b1;
    tick();
    check("rst_ready", 128'(bus.cmd_ready), 128'd1);

    // Single command, all fields 1, uop 1..16
    c = '{dep: 4'd1, reset_reg: 1'b1, uop_bgn: 13'd1, uop_end: 14'd16,
          iter_out: 14'd1, iter_in: 14'd1, dst_out: 11'd1, dst_in: 11'd1,
          src_out: 11'd1, src_in: 11'd1, wgt_out: 10'd1, wgt_in: 10'd1};
    drive(c);
    bus.insn_ready = 1'b1;
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("t1_valid", 128'(bus.insn_valid), 128'd1);
    check("t1_op", 128'(bus.insn[2:0]), 128'd2);
    check("t1_bgn", 128'(bus.insn[20:8]), 128'd1);
    check("t1_end", 128'(bus.insn[34:21]), 128'd16);
    check("t1_iout", 128'(bus.insn[48:35]), 128'd1);
    check("t1_wgtin", 128'(bus.insn[126:117]), 128'd1);
    check("t1_b127", 128'(bus.insn[127]), 128'd0);
    check("t1_word", bus.insn, pack_ref(c));
    tick();
    check("t1_cnt", 128'(issue_cnt), 128'd1);
    check("t1_level", 128'(level), 128'd0);

    // All fields at maximum: no truncation, bit 127 clear
    c = '1;
    drive(c);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("max_word", bus.insn, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA);
    tick();
    check("max_cnt", 128'(issue_cnt), 128'd2);

    // Fill to full with the core stalled
    bus.insn_ready = 1'b0;
    for (int k = 0; k < 5; k++) cmds[k] = make_cmd(k + 1);
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(cmds[k]);
      check("fill_ready", 128'(bus.cmd_ready), 128'd1);
      tick();
    end
    drive(cmds[4]);
    check("full_level", 128'(level), 128'd4);
    check("full_ready", 128'(bus.cmd_ready), 128'd0);
    tick();
    tick();
    check("hold_level", 128'(level), 128'd4);
    check("hold_insn", bus.insn, pack_ref(cmds[0]));
    check("hold_valid", 128'(bus.insn_valid), 128'd1);

    // Release stall: 5th command enters after first pop, FIFO order 1..5
    lv = '{4, 3, 3, 2, 1};
    bus.insn_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain_insn", bus.insn, pack_ref(cmds[i]));
      check("drain_level", 128'(level), 128'(lv[i]));
      tick();
      if (i == 1) bus.cmd_valid = 1'b0;
    end
    check("drain_empty", 128'(level), 128'd0);
    check("drain_cnt", 128'(issue_cnt), 128'd7);

    // Invalid commands: empty uop range, then zero inner loop count
    bus.insn_ready = 1'b0;
    cmds[0] = make_cmd(3);
    cmds[0].uop_bgn = 13'd16;
    cmds[0].uop_end = 14'd16;
    cmds[1] = make_cmd(4);
    cmds[1].iter_in = 14'd0;
    for (int i = 0; i < 2; i++) begin
      drive(cmds[i]);
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
`ifdef GEMM_ENC_CHECK_EN
      check("bad_err", 128'(err), 128'd1);
      check("bad_level", 128'(level), 128'd0);
      tick();
      check("bad_errclr", 128'(err), 128'd0);
`else
      check("bad_err", 128'(err), 128'd0);
      check("bad_level", 128'(level), 128'(i + 1));
`endif
    end
`ifdef GEMM_ENC_CHECK_EN
    base_cnt = 7;
`else
    check("bad_head", bus.insn, pack_ref(cmds[0]));
    bus.insn_ready = 1'b1;
    tick();
    check("bad_next", bus.insn, pack_ref(cmds[1]));
    tick();
    check("bad_drain", 128'(level), 128'd0);
    base_cnt = 9;
`endif
    check("bad_cnt", 128'(issue_cnt), 128'(base_cnt));

    // Streaming: push and pop every cycle
    bus.insn_ready = 1'b1;
    bus.cmd_valid  = 1'b1;
    for (int j = 0; j < 20; j++) begin
      c = make_cmd(j + 10);
      drive(c);
      tick();
      check("str_level", 128'(level), 128'd1);
      check("str_insn", bus.insn, pack_ref(c));
    end
    bus.cmd_valid = 1'b0;
    tick();
    check("str_empty", 128'(level), 128'd0);
    check("str_cnt", 128'(issue_cnt), 128'(base_cnt + 20));

    // Asynchronous reset mid-stall with three entries queued
    bus.insn_ready = 1'b0;
    bus.cmd_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(make_cmd(40 + k));
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("pre_level", 128'(level), 128'd3);
    check("pre_valid", 128'(bus.insn_valid), 128'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", 128'(bus.insn_valid), 128'd0);
    check("ar_insn", bus.insn, 128'd0);
    check("ar_level", 128'(level), 128'd0);
    check("ar_cnt", 128'(issue_cnt), 128'd0);
    tick();
    check("ar_hold", 128'(level), 128'd0);
    rst = 1'b1;
    tick();
    check("ar_ready", 128'(bus.cmd_ready), 128'd1);
    c = make_cmd(50);
    drive(c);
    bus.insn_ready = 1'b1;
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("ar_insn2", bus.insn, pack_ref(c));
    tick();
    check("ar_cnt2", 128'(issue_cnt), 128'd1);
    check("ar_level2", 128'(level), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
